// File: rtl/if_fetch_unit_if.sv
// Byte-wide instruction memory port between fetch and the memory arbiter.
// The fetch stage is the master; the arbiter/memory side is the slave.
interface if_fetch_unit_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_grant_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_grant_i,
        output mem_data_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: four byte reads per instruction, little-endian assembly,
// one-cycle presentation to IF/ID unless stalled, jump redirect at any time.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              stall_i,
    if_fetch_unit_if.master   mem,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_inst_o,
    output logic              if_busy_o
);

    typedef enum logic {S_FETCH, S_VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  recv_q, recv_d;
    logic        pending_q, pending_d;
    logic [23:0] buf_q, buf_d;
    logic        busy_q, busy_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        grant;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (jump_i) begin
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: if (pending_q && recv_q == 3'd3) state_d = S_VALID;
                S_VALID: if (!stall_i) state_d = S_FETCH;
            endcase
        end
    end

    // Request logic looks only at registers and jump_i, never at grant/data.
    assign mem.mem_req_o  = (state_q == S_FETCH) && (issued_q < 3'd4) && !jump_i;
    assign mem.mem_addr_o = pc_q + {29'd0, issued_q};
    assign grant          = mem.mem_req_o && mem.mem_grant_i;

    always_comb begin
        pc_d      = pc_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        pending_d = 1'b0;
        buf_d     = buf_q;
        busy_d    = busy_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        if (jump_i) begin
            pc_d     = jump_addr_i;
            issued_d = 3'd0;
            recv_d   = 3'd0;
            busy_d   = 1'b1;
        end else if (state_q == S_FETCH) begin
            pending_d = grant;
            if (grant) issued_d = issued_q + 3'd1;
            if (pending_q) begin
                recv_d = recv_q + 3'd1;
                unique case (1'b1)
                    recv_q == 3'd0: buf_d[7:0]   = mem.mem_data_i;
                    recv_q == 3'd1: buf_d[15:8]  = mem.mem_data_i;
                    recv_q == 3'd2: buf_d[23:16] = mem.mem_data_i;
                    default: begin
                        if_inst_d = {mem.mem_data_i, buf_q};
                        if_pc_d   = pc_q;
                        busy_d    = 1'b0;
                    end
                endcase
            end
        end else if (!stall_i) begin
            pc_d     = pc_q + 32'd4;
            issued_d = 3'd0;
            recv_d   = 3'd0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            issued_q  <= 3'd0;
            recv_q    <= 3'd0;
            pending_q <= 1'b0;
            buf_q     <= 24'd0;
            busy_q    <= 1'b1;
            if_pc_q   <= 32'd0;
            if_inst_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            issued_q  <= issued_d;
            recv_q    <= recv_d;
            pending_q <= pending_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    assign if_pc_o   = if_pc_q;
    assign if_inst_o = if_inst_q;
    assign if_busy_o = busy_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: byte memory model, scripted grant/jump/stall/reset
// stimulus, and a scoreboard of expected presented pc/inst pairs.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [31:0] jaddr;
    logic        stall;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        busy;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_i      (jump),
        .jump_addr_i (jaddr),
        .stall_i     (stall),
        .mem         (bus.master),
        .if_pc_o     (if_pc),
        .if_inst_o   (if_inst),
        .if_busy_o   (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];

    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_grant_i)
            bus.mem_data_i <= mem[bus.mem_addr_o[8:0]];
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    logic prev_busy = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [8:0] i0, i1, i2, i3;
        i0 = a[8:0];
        i1 = i0 + 9'd1;
        i2 = i0 + 9'd2;
        i3 = i0 + 9'd3;
        return {mem[i3], mem[i2], mem[i1], mem[i0]};
    endfunction

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = word_at(pc);
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && busy !== 1'b0; i++) step();
        check("wait_valid", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (sb.size() == 0) begin
                check("sb_extra", sb.size(), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pc", if_pc, e.pc);
                check("sb_inst", if_inst, e.inst);
            end
        end
        prev_busy = busy;
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h20; mem[7] = 8'h00;
        rst = 1'b1;
        jump = 1'b0;
        jaddr = 32'd0;
        stall = 1'b0;
        bus.mem_grant_i = 1'b1;
        repeat (2) step();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_pc", if_pc, 32'd0);
        check("rst_inst", if_inst, 32'd0);

        // Back-to-back fetch of the first two words with full grant.
        push(32'h0);
        push(32'h4);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_req", {31'd0, bus.mem_req_o}, 32'd1);
            check("t1_addr", bus.mem_addr_o, 32'(i));
            step();
        end
        check("t1_busy4", {31'd0, busy}, 32'd1);
        step();
        check("t1_busy5", {31'd0, busy}, 32'd0);
        check("t1_inst", if_inst, 32'h0010_0513);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", bus.mem_addr_o, 32'(4 + i));
            step();
        end
        wait_valid(3);
        check("t2_inst", if_inst, 32'h0020_0593);

        // Two-cycle grant gap on byte 2.
        push(32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("gap_a0", bus.mem_addr_o, 32'h0);
        step();
        check("gap_a1", bus.mem_addr_o, 32'h1);
        step();
        bus.mem_grant_i = 1'b0;
        #1;
        check("gap_a2", bus.mem_addr_o, 32'h2);
        step();
        check("gap_req", {31'd0, bus.mem_req_o}, 32'd1);
        check("gap_a2", bus.mem_addr_o, 32'h2);
        step();
        bus.mem_grant_i = 1'b1;
        check("gap_a2", bus.mem_addr_o, 32'h2);
        step();
        check("gap_a3", bus.mem_addr_o, 32'h3);
        step();
        check("gap_busy6", {31'd0, busy}, 32'd1);
        step();
        check("gap_busy7", {31'd0, busy}, 32'd0);

        // Stall for three cycles in S_VALID.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 1'b0;
            check("stl_busy", {31'd0, busy}, 32'd0);
            check("stl_inst", if_inst, 32'h0010_0513);
            check("stl_req", {31'd0, bus.mem_req_o}, 32'd0);
            step();
        end
        check("stl_next", bus.mem_addr_o, 32'h4);
        check("stl_req1", {31'd0, bus.mem_req_o}, 32'd1);

        // Jump while byte 1 data is returning.
        step();
        check("jmp_a5", bus.mem_addr_o, 32'h5);
        step();
        jump = 1'b1;
        jaddr = 32'h100;
        #1;
        check("jmp_req", {31'd0, bus.mem_req_o}, 32'd0);
        push(32'h100);
        step();
        jump = 1'b0;
        #1;
        check("jmp_addr", bus.mem_addr_o, 32'h100);
        check("jmp_req1", {31'd0, bus.mem_req_o}, 32'd1);
        wait_valid(8);

        // Jump in the 4th-byte capture cycle to an unaligned target.
        step();
        check("jc_a0", bus.mem_addr_o, 32'h104);
        repeat (4) step();
        jump = 1'b1;
        jaddr = 32'h1F1;
        push(32'h1F1);
        step();
        jump = 1'b0;
        #1;
        check("jc_busy", {31'd0, busy}, 32'd1);
        check("jc_addr", bus.mem_addr_o, 32'h1F1);
        check("jc_req", {31'd0, bus.mem_req_o}, 32'd1);
        wait_valid(8);

        // Jump near the top of the address space: addresses wrap.
        jump = 1'b1;
        jaddr = 32'hFFFF_FFFE;
        push(32'hFFFF_FFFE);
        step();
        jump = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", bus.mem_addr_o, 32'hFFFF_FFFE + 32'(i));
            step();
        end
        wait_valid(3);

        // Reset during the byte-2 request.
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rm_a0", bus.mem_addr_o, 32'h0);
        step();
        check("rm_a1", bus.mem_addr_o, 32'h1);
        step();
        check("rm_a2", bus.mem_addr_o, 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rm_busy", {31'd0, busy}, 32'd1);
        check("rm_addr", bus.mem_addr_o, 32'h0);
        check("rm_req", {31'd0, bus.mem_req_o}, 32'd1);
        push(32'h0);
        wait_valid(8);

        step();
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
